// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: size codes,
// FSM state encoding and the I/O space select bit.
package mem_ctrl_pkg;

    // Address bit that selects I/O space on the system bus.
    localparam int unsigned IO_BIT = 17;

    // Load/store size codes; the reserved code 3 behaves as a word.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Number of bus bytes moved for a given size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            SZ_W:    n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto
// the shared 8-bit system bus, splits them into byte transfers, assembles
// little-endian results and survives rdy_in pauses without repeating a
// committed byte.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IO_BIT = mem_ctrl_pkg::IO_BIT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,

    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,

    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    import mem_ctrl_pkg::*;

    // The I/O select bit has to name a real address bit.
    if (IO_BIT >= ADDR_W) begin : g_io_bit_check
        $error("IO_BIT must index a bit of the bus address");
    end

    state_e state_q, state_d;

    // Latched request
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic              is_if_q, is_if_d;

    // Byte sequencing: nxt = next byte to put on the bus, cmt = bytes committed.
    // iss: a byte is on the bus this cycle. pend: a read byte issued last cycle
    // with rdy high, due for capture at the coming edge.
    logic [2:0]        nxt_q, nxt_d;
    logic [2:0]        cmt_q, cmt_d;
    logic              iss_q, iss_d;
    logic              pend_q, pend_d;
    logic [31:0]       rdata_q, rdata_d;

    // Registered outputs
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic              grant_ls;
    logic              grant_if;
    logic              rd_last;
    logic              wr_last;

    // Fixed priority: load/store beats fetch; only sampled while idle and ready.
    assign grant_ls = (state_q == StIdle) && rdy_in && ls_req;
    assign grant_if = (state_q == StIdle) && rdy_in && !ls_req && if_req;

    // Last byte of a read is captured / last byte of a write is accepted this edge.
    assign rd_last = rdy_in && pend_q && ((cmt_q + 3'd1) == nbytes_q);
    assign wr_last = rdy_in && iss_q && ((cmt_q + 3'd1) == nbytes_q);

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ls) begin
                    state_d = ls_wr ? StWrite : StRead;
                end else if (grant_if) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (rd_last) begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                if (wr_last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    // Output/datapath decode: latch on grant, issue bytes, commit or roll back on rdy_in.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        nbytes_d   = nbytes_q;
        is_if_d    = is_if_q;
        nxt_d      = nxt_q;
        cmt_d      = cmt_q;
        iss_d      = 1'b0;
        pend_d     = 1'b0;
        rdata_d    = rdata_q;
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = 8'h00;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_ls || grant_if) begin
                    addr_d   = grant_ls ? ls_addr : if_addr;
                    wdata_d  = ls_wdata;
                    nbytes_d = grant_ls ? size_bytes(ls_size) : 3'd4;
                    is_if_d  = grant_if;
                    cmt_d    = 3'd0;
                    nxt_d    = 3'd1;
                    rdata_d  = '0;
                    // Byte 0 goes out in the cycle right after the grant edge.
                    iss_d    = 1'b1;
                    mem_a_d  = grant_ls ? ls_addr : if_addr;
                    if (grant_ls && ls_wr) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ls_wdata[7:0];
                    end
                end
            end

            StRead: begin
                if (!rdy_in) begin
                    // Anything in flight is lost; restart from the first uncommitted byte.
                    nxt_d = cmt_q;
                end else begin
                    pend_d = iss_q;
                    if (pend_q) begin
                        rdata_d[{cmt_q[1:0], 3'b000} +: 8] = mem_din;
                        cmt_d = cmt_q + 3'd1;
                    end
                    if (rd_last) begin
                        pend_d = 1'b0;
                        if (is_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = rdata_d;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = rdata_d;
                        end
                    end else if (nxt_q < nbytes_q) begin
                        iss_d   = 1'b1;
                        mem_a_d = addr_q + ADDR_W'(nxt_q);
                        nxt_d   = nxt_q + 3'd1;
                    end
                end
            end

            StWrite: begin
                if (!rdy_in) begin
                    nxt_d = cmt_q;
                end else begin
                    if (iss_q) begin
                        cmt_d = cmt_q + 3'd1;
                    end
                    if (wr_last) begin
                        ls_done_d = 1'b1;
                    end else if (nxt_q < nbytes_q) begin
                        iss_d      = 1'b1;
                        mem_a_d    = addr_q + ADDR_W'(nxt_q);
                        mem_wr_d   = 1'b1;
                        mem_dout_d = wdata_q[{nxt_q[1:0], 3'b000} +: 8];
                        nxt_d      = nxt_q + 3'd1;
                    end
                end
            end

            StDone: begin
                nxt_d = 3'd0;
                cmt_d = 3'd0;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any transfer silently.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            nbytes_q   <= 3'd0;
            is_if_q    <= 1'b0;
            nxt_q      <= 3'd0;
            cmt_q      <= 3'd0;
            iss_q      <= 1'b0;
            pend_q     <= 1'b0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= 8'h00;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            nbytes_q   <= nbytes_d;
            is_if_q    <= is_if_d;
            nxt_q      <= nxt_d;
            cmt_q      <= cmt_d;
            iss_q      <= iss_d;
            pend_q     <= pend_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller inside the cpu; drives the cpu's 8-bit system memory bus (mem_a/mem_wr/mem_dout/mem_din) that is shared with ram and hci I/O.
- Arbitrates between an instruction-fetch port (word reads) and a load/store port (1/2/4-byte reads/writes).
- Splits each request into sequential byte transfers, assembles little-endian results and pulses done.
- Honours rdy_in pauses (hci debug break).

Parameters:
- ADDR_W, 32, system bus address width.
- IO_BIT, 17, address bit that selects I/O space. Documentation only; no special sequencing.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- rdy_in  input  1  bus ready; low = cpu paused, bus owned by hci
- if_req  input  1  fetch request, held until if_done
- if_addr  input  32  fetch byte address
- if_done  output  1  one-cycle pulse; if_data valid in that cycle
- if_data  output  32  fetched word, little-endian
- ls_req  input  1  load/store request, held until ls_done
- ls_wr  input  1  1 = store, 0 = load
- ls_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- ls_addr  input  32  start byte address; no alignment required
- ls_wdata  input  32  store data; low N bytes used
- ls_done  output  1  one-cycle completion pulse
- ls_rdata  output  32  load data, zero-extended, valid while ls_done is high
- mem_din  input  8  read byte from bus
- mem_dout  output  8  write byte to bus
- mem_a  output  32  bus byte address
- mem_wr  output  1  1 = write

Behaviour:
- All outputs registered.
- Reset (async, rst_in high): state IDLE; mem_a=0, mem_wr=0, mem_dout=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0. An in-flight transfer is abandoned with no done pulse; the requester re-requests.
- States:
  - IDLE -> READ or WRITE on grant.
  - READ -> DONE after the last byte is captured.
  - WRITE -> DONE after the last byte is written.
  - DONE -> IDLE unconditionally.
- Requests are sampled only in IDLE with rdy_in=1. ls_req wins over if_req when both are high (fixed priority). Address, size and wdata are latched at the grant edge E0.
- Requesters drop req in their done cycle; req is never sampled in DONE. Back-to-back requests therefore have one IDLE cycle between them.
- N = 1/2/4 bytes (fetch always 4). Byte k uses address latched_addr+k, with 32-bit wrap.
- Read timing (ram/hci have 1-cycle latency):
  - Byte k address driven in the cycle after edge E(k).
  - Byte k sampled from mem_din at E(k+2) into bits [8k+7:8k].
  - Done is high in the cycle after E(N+1). Word read latency is 5 cycles from grant; byte read latency is 2.
- Write timing:
  - mem_a, mem_dout=byte k and mem_wr=1 are driven in the cycle after E(k).
  - Done is high in the cycle after E(N); mem_wr=0 in that cycle. Word write takes 4 cycles.
- Outside an active issue cycle, mem_a=0 and mem_wr=0. An I/O address is never presented longer than its own issue cycle, because I/O reads have side effects.
- rdy_in low:
  - No state advance, no done pulse, no new grant.
  - A read byte commits only if rdy_in was 1 in its issue cycle and at its capture edge; otherwise it is re-issued after rdy_in returns.
  - A write byte commits only if rdy_in=1 in its issue cycle; otherwise it is re-issued with the same address and data.
  - Re-issue resumes from the first uncommitted byte; committed bytes are never re-issued.
- if_data and ls_rdata hold their last value after done.

Decomposition:
- Shared package holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - FSM state encoding IDLE/READ/WRITE/DONE;
  - the IO_BIT constant shared with top-level decode.
- Single module; the arbiter and byte sequencer are inline, and no sub-module is needed.

Test Plan:
- Fetch, ram bytes 0x1000..0x1003 = 13 05 00 00, if_req at 0x1000 -> mem_a 0x1000..0x1003 on consecutive cycles; if_done 5 cycles after grant; if_data=0x00000513.
- Store word 0xDEADBEEF at 0x2001 (misaligned) -> writes EF,BE,AD,DE to 0x2001..0x2004; ls_done after 4 cycles. A subsequent word load returns 0xDEADBEEF and a half load at 0x2003 returns 0x0000DEAD.
- if_req and ls_req (byte load at 0x30000) raised together -> load granted first, and only one bus read of 0x30000 occurs. Fetch is granted in the IDLE cycle after ls_done.
- Word read with rdy_in forced low for 3 cycles while byte 1 is in flight:
  - byte 0 is not re-read;
  - byte 1 is re-issued after rdy_in returns;
  - final data is correct;
  - done is delayed by exactly the lost cycles plus re-issue.
- Word store with rdy_in low during the byte-2 issue cycle -> byte 2 is re-issued; ram holds all 4 bytes correctly, with no duplicate or missing write.
- rst_in asserted mid word-read -> all outputs 0 immediately (async); no done pulse; a new request after reset completes normally.
